// File: rtl/wbmem_seq.sv
// ---------------------------------------------------------------------------
// wbmem_seq -- banked weight memory with a burst row sequencer.
//
// Holds NCH1 layer-1 banks and NCH2 layer-2 banks, each 2**AW x DW with a
// single synchronous read port. A burst reads len consecutive rows (address
// wraps modulo 2**AW) from one layer's banks and streams each row, all
// channels side by side, through a 2-entry output skid buffer.
//
// Handshake: a row transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, out_data/out_last hold their
// value. out_valid never drops without a transfer (except on reset).
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   start, layer, base,    burst request (sampled only in IDLE)
//   len
//   busy                   high whenever a burst is in progress
//   done                   one-cycle pulse after the last row (or after a
//                          len=0 start)
//   out_valid, out_ready,  output row stream; channel k at [k*DW +: DW],
//   out_last, out_data     channels NCH2.. are zero on layer-2 bursts
//   wr_en, wr_layer,       optional bank write port (read-first)
//   wr_ch, wr_addr,
//   wr_data
//
// Configuration macro: WBMEM_SEQ_WRITE_EN compiles in the wr_* port. Without
// it the banks are read-only.
// INIT_DIR names the init-file prefix (<INIT_DIR>w<ch>_<n>.mem); bank
// contents are supplied by the surrounding environment.
// ---------------------------------------------------------------------------
module wbmem_seq #(
  parameter int    DW       = 32,
  parameter int    AW       = 10,
  parameter int    NCH1     = 32,
  parameter int    NCH2     = 10,
  parameter string INIT_DIR = "weights/",
  localparam int   CHW      = (NCH1 > 1) ? $clog2(NCH1) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 layer,
  input  logic [AW-1:0]        base,
  input  logic [AW:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [NCH1*DW-1:0]   out_data
`ifdef WBMEM_SEQ_WRITE_EN
  ,
  input  logic                 wr_en,
  input  logic                 wr_layer,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int RW    = NCH1 * DW;
  localparam int CH2W  = (NCH2 > 1) ? $clog2(NCH2) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Banks
  // -------------------------------------------------------------------------
  logic [DW-1:0] l1_mem [NCH1][DEPTH];
  logic [DW-1:0] l2_mem [NCH2][DEPTH];

`ifdef WBMEM_SEQ_WRITE_EN
  // Writes to a channel the selected layer does not have are dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!wr_layer) begin
        if (32'(wr_ch) < NCH1) l1_mem[wr_ch][wr_addr] <= wr_data;
      end else begin
        if (32'(wr_ch) < NCH2) l2_mem[wr_ch[CH2W-1:0]][wr_addr] <= wr_data;
      end
    end
  end
`endif

  // Read registers of every bank. Not reset: their contents only matter
  // while infl_q marks them as holding a requested row.
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic [DW-1:0] l1_rd_q [NCH1];
  logic [DW-1:0] l2_rd_q [NCH2];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int c = 0; c < NCH1; c++) l1_rd_q[c] <= l1_mem[c][rd_addr];
      for (int c = 0; c < NCH2; c++) l2_rd_q[c] <= l2_mem[c][rd_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          layer_q, layer_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;        // reads still to issue
  logic          done_q, done_d;
  logic          infl_q, infl_d;      // a read result sits in the read regs
  logic          infl_last_q, infl_last_d;

  // Skid buffer
  logic [RW-1:0] ent_q [2];
  logic [RW-1:0] ent_d [2];
  logic [1:0]    elast_q, elast_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  logic [RW-1:0] row_data;
  logic          push;
  logic          pop;
  logic [1:0]    occ;
  logic          slot_free;

  // Row as seen from the read registers, for the latched layer.
  for (genvar k = 0; k < NCH1; k++) begin : g_row
    if (k < NCH2) begin : g_both
      assign row_data[k*DW +: DW] = layer_q ? l2_rd_q[k] : l1_rd_q[k];
    end else begin : g_l1_only
      assign row_data[k*DW +: DW] = layer_q ? '0 : l1_rd_q[k];
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent_q[rd_ptr_q];
  assign out_last  = out_valid && elast_q[rd_ptr_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  assign pop  = out_valid && out_ready;
  assign push = infl_q;
  // The in-flight read already owns a slot; a slot freed by this cycle's
  // pop may be claimed by a new read, which keeps one row per cycle.
  assign occ       = cnt_q + {1'b0, infl_q};
  assign slot_free = (occ < 2'd2) || pop;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    rd_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            // The first read is issued on the accepting edge itself so the
            // first row appears two cycles after the start cycle.
            layer_d = layer;
            rd_en   = 1'b1;
            rd_addr = base;
            rd_last = (len == (AW+1)'(1));
            addr_d  = base + AW'(1);
            rem_d   = len - (AW+1)'(1);
            state_d = (len == (AW+1)'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (slot_free) begin
          rd_en   = 1'b1;
          rd_last = (rem_q == (AW+1)'(1));
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ent_d       = ent_q;
    elast_d     = elast_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    infl_d      = rd_en;
    infl_last_d = rd_last;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      ent_d[wr_ptr_q]   = row_data;
      elast_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      layer_q     <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      ent_q[0]    <= '0;
      ent_q[1]    <= '0;
      elast_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      ent_q[0]    <= ent_d[0];
      ent_q[1]    <= ent_d[1];
      elast_q     <= elast_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wbmem_seq.sv
// ---------------------------------------------------------------------------
// tb_wbmem_seq -- directed bench for wbmem_seq.
// Bank contents come from a bench-side model that is copied into the DUT
// banks at time zero (the DUT is built with an empty INIT_DIR). Expected
// rows are computed from that model and queued when a burst is started.
// ---------------------------------------------------------------------------
module tb_wbmem_seq;
  localparam int DW = 32, AW = 10, NCH1 = 32, NCH2 = 10;
  localparam int DEPTH = 1 << AW;
  localparam int RW = NCH1 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, start, layer, out_ready;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, done, out_valid, out_last;
  logic [RW-1:0] out_data;
`ifdef WBMEM_SEQ_WRITE_EN
  logic          wr_en, wr_layer;
  logic [4:0]    wr_ch;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`endif

  wbmem_seq #(
    .DW(DW), .AW(AW), .NCH1(NCH1), .NCH2(NCH2), .INIT_DIR("")
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .layer(layer),
    .base(base), .len(len), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_data(out_data)
`ifdef WBMEM_SEQ_WRITE_EN
    ,
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data)
`endif
  );

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] m1 [NCH1][DEPTH];
  logic [DW-1:0] m2 [NCH2][DEPTH];
  logic [RW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int checks = 0;
  int errors = 0;
  int rows_seen = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_row(input logic lay, input int a);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH1; k++) begin
      if (!lay) r[k*DW +: DW] = m1[k][a];
      else if (k < NCH2) r[k*DW +: DW] = m2[k][a];
    end
    return r;
  endfunction

  function automatic logic rdy(input int i);
    if (i == 0) return 1'b1;
    if (i < 3) return 1'b0;
    return i[0];
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    logic [RW-1:0] er;
    logic          el;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data == prev_data, 1);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        check("row_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          el = exp_last_q.pop_front();
          for (int k = 0; k < NCH1; k++)
            check($sformatf("row%0d_ch%0d", rows_seen, k), out_data[k*DW +: DW], er[k*DW +: DW]);
          check($sformatf("row%0d_last", rows_seen), out_last, el);
        end
        rows_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the start edge with the
  // request inputs scrambled so only latched values can matter.
  task automatic do_start(input logic lay, input logic [AW-1:0] b, input int l);
    start = 1'b1;
    layer = lay;
    base  = b;
    len   = (AW+1)'(l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(model_row(lay, (int'(b) + i) % DEPTH));
      exp_last_q.push_back(i == l - 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    layer = ~lay;
    base  = b + AW'(13);
    len   = (AW+1)'(7);
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r0, d0;
    resetn = 1'b0; start = 1'b0; layer = 1'b0; base = '0; len = '0; out_ready = 1'b1;
`ifdef WBMEM_SEQ_WRITE_EN
    wr_en = 1'b0; wr_layer = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
`endif
    for (int c = 0; c < NCH1; c++)
      for (int a = 0; a < DEPTH; a++) begin
        m1[c][a] = {8'hA1, 8'(c), 16'(a)};
        dut.l1_mem[c][a] <= m1[c][a];
      end
    for (int c = 0; c < NCH2; c++)
      for (int a = 0; a < DEPTH; a++) begin
        m2[c][a] = {8'hB2, 8'(c), 16'(a)};
        dut.l2_mem[c][a] <= m2[c][a];
      end

    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data_zero", out_data == '0, 1);

    // Basic burst, start on the first edge after reset release.
    resetn = 1'b1;
    do_start(1'b0, 10'd0, 4);
    check("t1_busy", busy, 1);
    check("t1_lat_v0", out_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_valid%0d", i), out_valid, 1);
      check($sformatf("t1_last%0d", i), out_last, (i == 3));
      check($sformatf("t1_nodone%0d", i), done, 0);
      @(posedge clk); #1;
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_valid_end", out_valid, 0);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);
    check("t1_drained", exp_q.size(), 0);

    // Layer-2 burst with address wrap.
    do_start(1'b1, 10'd1022, 4);
    wait_done(20, "t2_done");
    check("t2_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Back-pressure.
    r0 = rows_seen; d0 = done_cnt;
    out_ready = rdy(0);
    do_start(1'b0, 10'd100, 5);
    for (int i = 1; i < 40; i++) begin
      out_ready = rdy(i);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("t3_rows", rows_seen - r0, 5);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_drained", exp_q.size(), 0);

    // len = 0, then start while running.
    d0 = done_cnt;
    do_start(1'b0, 10'd50, 0);
    check("t4_done0", done, 1);
    check("t4_busy0", busy, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_novalid%0d", i), out_valid, 0);
      @(posedge clk); #1;
    end
    check("t4_done0_cnt", done_cnt - d0, 1);
    d0 = done_cnt;
    do_start(1'b0, 10'd200, 6);
    @(posedge clk); #1;
    start = 1'b1; layer = 1'b1; base = 10'd5; len = 11'd3;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(20, "t4_done_run");
    repeat (4) begin @(posedge clk); #1; end
    check("t4_done_cnt", done_cnt - d0, 1);
    check("t4_busy_idle", busy, 0);
    check("t4_drained", exp_q.size(), 0);

    // Reset mid-burst.
    r0 = rows_seen;
    do_start(1'b0, 10'd300, 8);
    for (int n = 0; n < 20; n++) begin
      if (rows_seen - r0 >= 2) break;
      @(posedge clk); #1;
    end
    check("t5_rows_before_rst", rows_seen - r0, 2);
    resetn = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_data_zero", out_data == '0, 1);
    exp_q.delete();
    exp_last_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_post_valid%0d", i), out_valid, 0);
      @(posedge clk); #1;
    end
    check("t5_no_done", done_cnt - d0, 0);
    do_start(1'b1, 10'd3, 3);
    wait_done(20, "t5_done_new");
    check("t5_drained", exp_q.size(), 0);
    @(posedge clk); #1;

`ifdef WBMEM_SEQ_WRITE_EN
    // Write port, including a write to a channel layer 2 does not have.
    wr_en = 1'b1; wr_layer = 1'b0; wr_ch = 5'd5; wr_addr = 10'd7; wr_data = 32'hDEADBEEF;
    m1[5][7] = 32'hDEADBEEF;
    @(posedge clk); #1;
    wr_layer = 1'b1; wr_ch = 5'd12; wr_data = 32'h12345678;
    @(posedge clk); #1;
    wr_en = 1'b0;
    do_start(1'b0, 10'd7, 1);
    wait_done(20, "t6_done");
    check("t6_drained", exp_q.size(), 0);
    do_start(1'b1, 10'd7, 1);
    wait_done(20, "t6_done_l2");
    check("t6_drained_l2", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wbmem_seq.md
WBMEM_SEQ -- requirements
Module: wbmem_seq

Interface
REQ-001 SHALL have parameter DW, default 32, meaning word width per channel.
REQ-002 SHALL have parameter AW, default 10, meaning address width; depth per bank = 2**AW.
REQ-003 SHALL have parameter NCH1, default 32, meaning channel count of layer-1 ([W1|b1]) banks.
REQ-004 SHALL have parameter NCH2, default 10, meaning channel count of layer-2 ([W2|b2]) banks; NCH2 <= NCH1.
REQ-005 SHALL have parameter INIT_DIR, default "weights/", meaning directory prefix for init files.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  request a burst; accepted only in IDLE.
REQ-009 SHALL have port layer  input  1  burst layer select, 0 = layer-1 banks, 1 = layer-2 banks.
REQ-010 SHALL have port base  input  AW  first row address of burst.
REQ-011 SHALL have port len  input  AW+1  row count of burst, 0 to 2**AW.
REQ-012 SHALL have port busy  output  1  high outside IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port out_valid  output  1  out_data holds a valid row.
REQ-015 SHALL have port out_ready  input  1  consumer accepts row when high with out_valid.
REQ-016 SHALL have port out_last  output  1  marks final row of burst.
REQ-017 SHALL have port out_data  output  NCH1*DW  row; channel k at bits [k*DW +: DW].
REQ-018 SHALL have ports wr_en (1), wr_layer (1), wr_ch (clog2(NCH1)), wr_addr (AW), wr_data (DW), all inputs, present only per REQ-034.

Function
REQ-019 SHALL hold NCH1+NCH2 banks of 2**AW x DW, each a synchronous single-read-port array, initialised from INIT_DIR files w<ch>_<layer>.mem (two-digit ch).
REQ-020 SHALL implement FSM IDLE -> RUN on start (len>0), RUN -> DRAIN when last read issued, DRAIN -> IDLE when last row accepted; IDLE -> DONE-pulse-only on start with len=0.
REQ-021 SHALL latch layer, base, len on the accepted start; later input changes have no effect on the burst.
REQ-022 SHALL read row i at address (base+i) mod 2**AW, i = 0..len-1, in order; wrap-around is silent.
REQ-023 SHALL give first out_valid exactly 2 cycles after the start cycle when out_ready is held high.
REQ-024 SHALL sustain one row per cycle with out_ready held high.
REQ-025 SHALL buffer rows in a 2-entry output skid buffer, issuing a read only when a slot is free counting the in-flight read; no row dropped or duplicated.
REQ-026 SHALL keep out_data, out_last stable while out_valid && !out_ready.
REQ-027 SHALL drive channels NCH2..NCH1-1 of out_data to zero on layer-2 bursts.
REQ-028 SHALL assert out_last only with the row i = len-1.
REQ-029 SHALL pulse done the cycle after the last-row handshake (or the cycle after start when len=0) and return to IDLE that same cycle.
REQ-030 SHALL ignore start while busy.

Reset
REQ-031 SHALL on resetn low immediately force IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, skid buffer empty.
REQ-032 SHALL abort any burst on reset mid-operation with no further rows or done; bank contents are not affected by reset.
REQ-033 SHALL accept start on the first rising edge after resetn deasserts.

Configuration
REQ-034 SHALL compile the write port only when WBMEM_SEQ_WRITE_EN is defined: wr_en high writes wr_data to bank (wr_layer, wr_ch) at wr_addr on that edge; wr_ch >= channel count of wr_layer is ignored; same-cycle read of the written address returns old data (read-first).
REQ-035 SHALL, without WBMEM_SEQ_WRITE_EN, omit the wr_* ports; banks are read-only, contents from init files only.

Verification
REQ-036 SHALL cover: layer=0, base=0, len=4, out_ready=1 -> out_valid at start+2, rows 0..3 on four consecutive cycles, out_last on row 3, done on following cycle.
REQ-037 SHALL cover: layer=1, base=1022, len=4 -> rows at addresses 1022,1023,0,1 in order, channels 10..31 zero.
REQ-038 SHALL cover: len=5, out_ready toggling 1,0,0,1,0,1... -> exactly 5 rows, correct order, out_data stable during stalls.
REQ-039 SHALL cover: start with len=0 -> done pulse next cycle, no out_valid; start during RUN -> ignored.
REQ-040 SHALL cover: resetn low at row 2 of len=8 burst -> all outputs zero immediately, no done; new burst after release correct.
REQ-041 SHALL cover, with WBMEM_SEQ_WRITE_EN: write 0xDEADBEEF to layer 0, ch 5, addr 7, then burst base=7 len=1 -> channel 5 reads 0xDEADBEEF.
